// File: rtl/id_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_regfile_pkg
// Description : Shared types and constants for the decode-stage register
//               file and the write-back stage that feeds it.
// Revision    : 1.0 - initial release
// ============================================================================
package id_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : id_regfile_pkg
`default_nettype wire

// File: rtl/id_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : id_regfile_if
// Description : Bundle of write-back, read-port and issue/scoreboard signals
//               between the pipeline (master) and the register file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface id_regfile_if #(
  parameter int XLEN = 32,
  parameter int REGS = 32
);
  import id_regfile_pkg::*;

  // write-back feedback path
  logic [XLEN-1:0] wb_write_data_in;
  reg_addr_t       wb_rd_addr_in;
  logic            wb_reg_write_en_in;

  // decode read ports
  reg_addr_t       rs1_addr_in;
  reg_addr_t       rs2_addr_in;
  logic [XLEN-1:0] rs1_data_out;
  logic [XLEN-1:0] rs2_data_out;

  // issue / scoreboard
  logic            issue_valid_in;
  logic            issue_is_load_in;
  reg_addr_t       issue_rd_in;
  logic            flush_in;
  logic            stall_out;
  logic [REGS-1:0] pending_out;

  modport master (
    output wb_write_data_in, wb_rd_addr_in, wb_reg_write_en_in,
    output rs1_addr_in, rs2_addr_in,
    output issue_valid_in, issue_is_load_in, issue_rd_in, flush_in,
    input  rs1_data_out, rs2_data_out, stall_out, pending_out
  );

  modport slave (
    input  wb_write_data_in, wb_rd_addr_in, wb_reg_write_en_in,
    input  rs1_addr_in, rs2_addr_in,
    input  issue_valid_in, issue_is_load_in, issue_rd_in, flush_in,
    output rs1_data_out, rs2_data_out, stall_out, pending_out
  );

endinterface : id_regfile_if
`default_nettype wire

// File: rtl/id_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : id_scoreboard
// Description : Pending-load scoreboard. One bit per architectural register,
//               set by an issuing load, cleared by its write-back, wiped by
//               a flush. Bit 0 never becomes pending.
// Revision    : 1.0 - initial release
// ============================================================================
module id_scoreboard
  import id_regfile_pkg::*;
#(
  parameter int REGS = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            set_en,
  input  wire reg_addr_t       set_addr,
  input  wire logic            clr_en,
  input  wire reg_addr_t       clr_addr,
  input  wire logic            flush,
  input  wire reg_addr_t       rs1_addr,
  input  wire reg_addr_t       rs2_addr,
  output logic                 pend_rs1,
  output logic                 pend_rs2,
  output logic [REGS-1:0]      pending_out
);

  logic [REGS-1:0] pending_q;
  logic [REGS-1:0] pending_d;

  // next pending vector: clear, then set (set wins), then flush overrides all
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < REGS; i++) begin
      if (clr_en && (clr_addr == REG_ADDR_W'(i))) pending_d[i] = 1'b0;
      if (set_en && (set_addr == REG_ADDR_W'(i))) pending_d[i] = 1'b1;
    end
    if (flush) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  // pending register; reset beats every set, clear and flush
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // pending lookup for both read addresses; addresses beyond REGS read 0
  always_comb begin
    pend_rs1 = 1'b0;
    pend_rs2 = 1'b0;
    for (int i = 1; i < REGS; i++) begin
      if (rs1_addr == REG_ADDR_W'(i)) pend_rs1 = pending_q[i];
      if (rs2_addr == REG_ADDR_W'(i)) pend_rs2 = pending_q[i];
    end
  end

  assign pending_out = pending_q;

endmodule : id_scoreboard
`default_nettype wire

// File: rtl/id_regfile.sv
`default_nettype none
// ============================================================================
// Module      : id_regfile
// Description : Decode-stage register file with two combinational read
//               ports, write-back write port, x0 hardwired to zero and an
//               integrated load scoreboard producing a read-after-load stall.
//               Build option: REGFILE_WB_BYPASS_EN - when defined, a WB write
//               in the current cycle is forwarded to matching read ports and
//               masks the pending stall; when undefined, reads see the array
//               only and a matching WB write forces a one-cycle stall.
// Revision    : 1.0 - initial release
// ============================================================================
module id_regfile #(
  parameter int XLEN = 32,
  parameter int REGS = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  id_regfile_if.slave rf
);
  import id_regfile_pkg::*;

  logic [REGS-1:0][XLEN-1:0] regs_q;
  logic [REGS-1:0][XLEN-1:0] regs_d;

  logic [XLEN-1:0] rs1_arr;
  logic [XLEN-1:0] rs2_arr;
  logic            wb_match1;
  logic            wb_match2;
  logic            pend_rs1;
  logic            pend_rs2;
  logic            sb_set_en;

  // array write: one entry updated per cycle, entry 0 pinned to zero
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < REGS; i++) begin
      if (rf.wb_reg_write_en_in && (rf.wb_rd_addr_in == REG_ADDR_W'(i)))
        regs_d[i] = rf.wb_write_data_in;
    end
    regs_d[0] = '0;
  end

  // storage register; reset clears every entry and drops any write
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  // array read for both ports; address 0 and out-of-range addresses give 0
  always_comb begin
    rs1_arr = '0;
    rs2_arr = '0;
    for (int i = 1; i < REGS; i++) begin
      if (rf.rs1_addr_in == REG_ADDR_W'(i)) rs1_arr = regs_q[i];
      if (rf.rs2_addr_in == REG_ADDR_W'(i)) rs2_arr = regs_q[i];
    end
  end

  // same-cycle WB write targeting a (non-zero) read address
  assign wb_match1 = rf.wb_reg_write_en_in && (rf.wb_rd_addr_in != REG_ZERO) &&
                     (rf.wb_rd_addr_in == rf.rs1_addr_in);
  assign wb_match2 = rf.wb_reg_write_en_in && (rf.wb_rd_addr_in != REG_ZERO) &&
                     (rf.wb_rd_addr_in == rf.rs2_addr_in);

  assign sb_set_en = rf.issue_valid_in && rf.issue_is_load_in &&
                     (rf.issue_rd_in != REG_ZERO);

  id_scoreboard #(
    .REGS (REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (sb_set_en),
    .set_addr    (rf.issue_rd_in),
    .clr_en      (rf.wb_reg_write_en_in),
    .clr_addr    (rf.wb_rd_addr_in),
    .flush       (rf.flush_in),
    .rs1_addr    (rf.rs1_addr_in),
    .rs2_addr    (rf.rs2_addr_in),
    .pend_rs1    (pend_rs1),
    .pend_rs2    (pend_rs2),
    .pending_out (rf.pending_out)
  );

`ifdef REGFILE_WB_BYPASS_EN
  // write-first: the retiring WB value is both forwarded and stall-clearing
  assign rf.rs1_data_out = wb_match1 ? rf.wb_write_data_in : rs1_arr;
  assign rf.rs2_data_out = wb_match2 ? rf.wb_write_data_in : rs2_arr;
  assign rf.stall_out    = (pend_rs1 && !wb_match1) || (pend_rs2 && !wb_match2);
`else
  // read-old: a matching WB write holds ID one cycle until the array updates
  assign rf.rs1_data_out = rs1_arr;
  assign rf.rs2_data_out = rs2_arr;
  assign rf.stall_out    = pend_rs1 || pend_rs2 || wb_match1 || wb_match2;
`endif

endmodule : id_regfile
`default_nettype wire

// File: tb/tb_id_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_regfile
// Description : Self-checking bench for id_regfile: reset sweep, a table of
//               directed per-cycle vectors, and a load-to-use sequence.
//               Expected values follow REGFILE_WB_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_regfile;
  import id_regfile_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        wb_en;
    reg_addr_t   wb_addr;
    xlen_data_t  wb_data;
    reg_addr_t   rs1;
    reg_addr_t   rs2;
    logic        iss_v;
    logic        iss_ld;
    reg_addr_t   iss_rd;
    logic        flush;
    xlen_data_t  e_rs1;
    xlen_data_t  e_rs2;
    logic        e_stall;
    logic [31:0] e_pend;
  } vec_t;

  localparam int NV = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NV];

  id_regfile_if #(.XLEN(32), .REGS(32)) bus ();

  id_regfile #(.XLEN(32), .REGS(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic we, input reg_addr_t wa,
                              input xlen_data_t wd, input reg_addr_t a1, input reg_addr_t a2,
                              input logic iv, input logic il, input reg_addr_t ird,
                              input logic fl, input xlen_data_t e1, input xlen_data_t e2,
                              input logic es, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
    v.rs1 = a1; v.rs2 = a2; v.iss_v = iv; v.iss_ld = il; v.iss_rd = ird;
    v.flush = fl; v.e_rs1 = e1; v.e_rs2 = e2; v.e_stall = es; v.e_pend = ep;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst                    = v.rst;
    bus.wb_reg_write_en_in = v.wb_en;
    bus.wb_rd_addr_in      = v.wb_addr;
    bus.wb_write_data_in   = v.wb_data;
    bus.rs1_addr_in        = v.rs1;
    bus.rs2_addr_in        = v.rs2;
    bus.issue_valid_in     = v.iss_v;
    bus.issue_is_load_in   = v.iss_ld;
    bus.issue_rd_in        = v.iss_rd;
    bus.flush_in           = v.flush;
  endtask

  task automatic idle(input reg_addr_t a1, input reg_addr_t a2);
    drive(mk(0, 0, 0, 0, a1, a2, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // rst wb  wa  wd            rs1 rs2 iv il ird fl  e_rs1                 e_rs2         stall  pend
    vecs[0]  = mk(0, 0, 0,  0,            1,  31, 0, 0, 0, 0, 0,                    0,            0,     0);
    vecs[1]  = mk(0, 1, 5,  32'hDEADBEEF, 5,  0,  0, 0, 0, 0, BYP ? 32'hDEADBEEF : 0, 0,         !BYP,  0);
    vecs[2]  = mk(0, 0, 0,  0,            5,  5,  0, 0, 0, 0, 32'hDEADBEEF,         32'hDEADBEEF, 0,    0);
    vecs[3]  = mk(0, 1, 0,  32'h1234,     0,  5,  0, 0, 0, 0, 0,                    32'hDEADBEEF, 0,    0);
    vecs[4]  = mk(0, 0, 0,  0,            0,  0,  0, 0, 0, 0, 0,                    0,            0,     0);
    vecs[5]  = mk(0, 1, 7,  42,           7,  5,  0, 0, 0, 0, BYP ? 42 : 0,         32'hDEADBEEF, !BYP, 0);
    vecs[6]  = mk(0, 0, 0,  0,            7,  0,  0, 0, 0, 0, 42,                   0,            0,     0);
    vecs[7]  = mk(0, 0, 0,  0,            7,  3,  1, 1, 3, 0, 42,                   0,            0,     0);
    vecs[8]  = mk(0, 0, 0,  0,            7,  3,  0, 0, 0, 0, 42,                   0,            1,     32'h8);
    vecs[9]  = mk(0, 0, 0,  0,            0,  3,  0, 0, 0, 0, 0,                    0,            1,     32'h8);
    vecs[10] = mk(0, 1, 3,  9,            0,  3,  0, 0, 0, 0, 0,                    BYP ? 9 : 0,  !BYP,  32'h8);
    vecs[11] = mk(0, 0, 0,  0,            0,  3,  0, 0, 0, 0, 0,                    9,            0,     0);
    vecs[12] = mk(0, 1, 4,  77,           4,  0,  1, 1, 4, 0, BYP ? 77 : 0,         0,            !BYP,  0);
    vecs[13] = mk(0, 0, 0,  0,            4,  0,  0, 0, 0, 0, 77,                   0,            1,     32'h10);
    vecs[14] = mk(0, 1, 4,  78,           4,  0,  0, 0, 0, 0, BYP ? 78 : 77,        0,            !BYP,  32'h10);
    vecs[15] = mk(0, 0, 0,  0,            0,  0,  1, 1, 3, 0, 0,                    0,            0,     0);
    vecs[16] = mk(0, 0, 0,  0,            0,  0,  1, 1, 8, 0, 0,                    0,            0,     32'h8);
    vecs[17] = mk(0, 0, 0,  0,            3,  8,  0, 0, 0, 1, 9,                    0,            1,     32'h108);
    vecs[18] = mk(0, 0, 0,  0,            3,  8,  0, 0, 0, 0, 9,                    0,            0,     0);
    vecs[19] = mk(0, 0, 0,  0,            9,  0,  1, 1, 9, 1, 0,                    0,            0,     0);
    vecs[20] = mk(0, 0, 0,  0,            9,  0,  1, 0, 10, 0, 0,                   0,            0,     0);
    vecs[21] = mk(0, 0, 0,  0,            10, 0,  1, 1, 0, 0, 0,                    0,            0,     0);
    vecs[22] = mk(0, 0, 0,  0,            0,  0,  0, 0, 0, 0, 0,                    0,            0,     0);
    vecs[23] = mk(1, 1, 10, 32'h55,       10, 5,  1, 1, 11, 0, BYP ? 32'h55 : 0,    32'hDEADBEEF, !BYP, 0);
    vecs[24] = mk(0, 0, 0,  0,            10, 5,  0, 0, 0, 0, 0,                    0,            0,     0);

    idle(0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset sweep: every register reads zero on both ports
    for (int i = 1; i < 32; i++) begin
      bus.rs1_addr_in = reg_addr_t'(i);
      bus.rs2_addr_in = reg_addr_t'(32 - i);
      #1;
      check($sformatf("reset rs1 x%0d", i), 64'(bus.rs1_data_out), 64'd0);
      check($sformatf("reset rs2 x%0d", 32 - i), 64'(bus.rs2_data_out), 64'd0);
    end
    check("reset stall", 64'(bus.stall_out), 64'd0);
    check("reset pending", 64'(bus.pending_out), 64'd0);
    @(posedge clk);
    #1;

    // directed per-cycle vectors: check combinational outputs, then clock
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d rs1", i), 64'(bus.rs1_data_out), 64'(vecs[i].e_rs1));
      check($sformatf("v%0d rs2", i), 64'(bus.rs2_data_out), 64'(vecs[i].e_rs2));
      check($sformatf("v%0d stall", i), 64'(bus.stall_out), 64'(vecs[i].e_stall));
      check($sformatf("v%0d pending", i), 64'(bus.pending_out), 64'(vecs[i].e_pend));
      @(posedge clk);
      #1;
    end

    // load-to-use: stall holds across several cycles until the WB write
    drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 12, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      idle(12, 0);
      #1;
      check($sformatf("ltu hold c%0d stall", c), 64'(bus.stall_out), 64'd1);
      check($sformatf("ltu hold c%0d pending", c), 64'(bus.pending_out), 64'h1000);
      @(posedge clk);
      #1;
    end
    drive(mk(0, 1, 12, 32'hABC, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("ltu wb stall", 64'(bus.stall_out), 64'(!BYP));
    check("ltu wb rs1", 64'(bus.rs1_data_out), BYP ? 64'hABC : 64'h0);
    @(posedge clk);
    #1;
    idle(12, 12);
    #1;
    check("ltu after stall", 64'(bus.stall_out), 64'd0);
    check("ltu after rs1", 64'(bus.rs1_data_out), 64'hABC);
    check("ltu after rs2", 64'(bus.rs2_data_out), 64'hABC);
    check("ltu after pending", 64'(bus.pending_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_id_regfile
`default_nettype wire

// File: doc/id_regfile.md
# id_regfile

Decode-stage register file with integrated load scoreboard. It is the receiving end of the write-back feedback path: it consumes the write data, destination address and write enable driven by the WB stage and serves two combinational read ports to ID. It also tracks destination registers of in-flight loads and asserts a stall when ID reads one of them before its write-back.

## Interface
Parameters:
- XLEN, 32, register data width.
- REGS, 32, number of architectural registers; address width is fixed at 5 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_write_data_in  in  XLEN  write-back data.
- wb_rd_addr_in  in  5  write-back destination.
- wb_reg_write_en_in  in  1  write-back enable.
- rs1_addr_in  in  5  read port 1 address.
- rs2_addr_in  in  5  read port 2 address.
- rs1_data_out  out  XLEN  read port 1 data (combinational).
- rs2_data_out  out  XLEN  read port 2 data (combinational).
- issue_valid_in  in  1  ID is issuing an instruction this cycle (not stalled).
- issue_is_load_in  in  1  the issuing instruction is a load.
- issue_rd_in  in  5  destination of the issuing instruction.
- flush_in  in  1  pipeline flush; cancels every pending load.
- stall_out  out  1  read-after-load hazard; ID must hold.
- pending_out  out  REGS  scoreboard bit vector, for debug and trace.

## Operation
- Storage: REGS × XLEN array. x0 is hardwired to 0: writes to address 0 are dropped and reads of address 0 return 0.
- Write: at the clock edge, if wb_reg_write_en_in and wb_rd_addr_in != 0, the array entry is set to wb_write_data_in.
- Read: rsN_data_out = 0 when rsN_addr_in == 0; otherwise the bypass value (see Configuration); otherwise the array entry.
- Scoreboard: one pending bit per register. Bit 0 is always 0.
  - Set: at the edge, pending[issue_rd_in] <= 1 when issue_valid_in && issue_is_load_in && issue_rd_in != 0.
  - Clear: at the edge, pending[wb_rd_addr_in] <= 0 when wb_reg_write_en_in.
  - Set and clear of the same register in the same cycle: set wins (a new load supersedes the retiring write).
  - flush_in clears all bits. A set in the same cycle as flush_in is also dropped.
- stall_out = (pending[rs1_addr_in] && !hit1) || (pending[rs2_addr_in] && !hit2). hitN is true when the WB write in the current cycle targets rsN_addr_in, and is true only when bypass is compiled in.
- ALU-producer hazards are not tracked here; EX/MEM forwarding resolves them.

## Timing
- Reset: every array entry is 0, pending_out = 0, stall_out = 0, and rsN_data_out = 0 for any address.
- Write latency: 1 cycle. The value is visible in the array from the cycle after the edge.
- Reads and stall_out are purely combinational from the current inputs and state; there is no read latency.
- Load-to-use: a load issued in cycle T sets its pending bit at T+1. stall_out holds until the WB write cycle (with bypass) or until the cycle after it (without bypass).
- rst asserted mid-operation takes priority over every write, set, clear and flush in that cycle.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - A same-cycle WB write to rsN (with wb_rd_addr_in != 0) drives wb_write_data_in onto rsN_data_out (write-first behaviour).
  - hitN masks the pending stall in that cycle.
- REGFILE_WB_BYPASS_EN undefined:
  - Reads return array contents only, so the old value is visible during the WB cycle.
  - stall_out is additionally asserted when wb_reg_write_en_in && wb_rd_addr_in == rsN_addr_in != 0, giving a one-cycle hold.

## Structure
- Shared package: XLEN, REG_ADDR_W = 5, REG_ZERO = 5'd0, and the reg-address and data typedefs. Both the WB stage and this block use them.
- One sub-module, id_scoreboard: pending vector, set/clear/flush logic and pending_out. Storage and read muxing stay in id_regfile.

## Test plan
- Reset then read x1..x31 -> all read 0, stall_out = 0, pending_out = 0.
- WB write x5 = 0xDEADBEEF, then read x5 next cycle -> 0xDEADBEEF. WB write x0 = 0x1234 -> x0 still reads 0.
- Same-cycle WB write x7 = 42 with rs1 = x7 -> reads 42 with bypass. Without bypass it reads the old value and stall_out = 1 for that cycle.
- Issue load to x3. Next cycle rs2 = x3 -> stall_out = 1 until the WB write x3 = 9; then rs2 reads 9 and stall_out = 0.
- Issue load x4 in the same cycle as a WB write to x4 -> pending[4] remains 1 afterwards.
- Issue loads x3 and x8, then flush_in -> pending_out = 0 and stall_out = 0. Assert rst mid-write -> array entry stays 0.
